// File: rtl/step_fsm.sv
// Single-step controller for the debug unit.
// Runs the pipeline one cycle per host STEP command and requests a dump after each.
module step_fsm #(
    parameter int UART_BITS        = 8,
    parameter int CLK_COUNTER_BITS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_rx_done,
    input  logic [UART_BITS-1:0]        i_rx_data,
    input  logic                        i_send_done,
    output logic                        o_enable,
    output logic                        o_send_start,
    output logic [CLK_COUNTER_BITS-1:0] o_clk_count,
    output logic                        o_done
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_SEND = 3'd2;
    localparam logic [2:0] WAIT_CMD  = 3'd3;
    localparam logic [2:0] STEP      = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [UART_BITS-1:0] OP_STEP = UART_BITS'(4);
    localparam logic [UART_BITS-1:0] OP_STOP = UART_BITS'(5);

    logic [2:0]                  state;
    logic [2:0]                  state_next;
    logic [CLK_COUNTER_BITS-1:0] count;

    // Next-state decode; stray strobes outside their waiting state are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) state_next = SEND;
            end
            SEND: begin
                state_next = WAIT_SEND;
            end
            WAIT_SEND: begin
                if (i_send_done) state_next = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (i_rx_done) begin
                    if (i_rx_data == OP_STEP) begin
                        state_next = STEP;
                    end else if (i_rx_data == OP_STOP) begin
                        state_next = DONE;
                    end
                end
            end
            STEP: begin
                state_next = SEND;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and step counter; counter clears on session start and
    // advances as the STEP cycle completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && i_start) begin
                count <= '0;
            end else if (state == STEP) begin
                count <= count + 1'b1;
            end
        end
    end

    assign o_enable     = (state == STEP);
    assign o_send_start = (state == SEND);
    assign o_done       = (state == DONE);
    assign o_clk_count  = count;

endmodule

// File: tb/tb_step_fsm.sv
// Directed self-checking bench for step_fsm.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_step_fsm;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_rx_done;
    logic [7:0]  i_rx_data;
    logic        i_send_done;
    logic        o_enable;
    logic        o_send_start;
    logic [31:0] o_clk_count;
    logic        o_done;

    int n_checks;
    int n_fail;

    step_fsm #(
        .UART_BITS(8),
        .CLK_COUNTER_BITS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_rx_done(i_rx_done),
        .i_rx_data(i_rx_data),
        .i_send_done(i_send_done),
        .o_enable(o_enable),
        .o_send_start(o_send_start),
        .o_clk_count(o_clk_count),
        .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b000, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_outs: got en/ss/dn=%b%b%b cnt=%0d want 000 cnt=0",
                     o_enable, o_send_start, o_done, o_clk_count);
        end
        i_rx_done = 1'b1;
        i_rx_data = 8'd4;
        tick();
        i_rx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b000, 32'd0}) begin
                n_fail++;
                $display("FAIL idle_rx_ignored[%0d]: got en/ss/dn=%b%b%b cnt=%0d want 000 cnt=0",
                         i, o_enable, o_send_start, o_done, o_clk_count);
            end
            tick();
        end
    endtask

    task automatic test_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b010, 32'd0}) begin
            n_fail++;
            $display("FAIL start_send: got en/ss/dn=%b%b%b cnt=%0d want 010 cnt=0",
                     o_enable, o_send_start, o_done, o_clk_count);
        end
        tick();
        n_checks++;
        if ({o_enable, o_send_start, o_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL start_send_single: got en/ss/dn=%b%b%b want 000",
                     o_enable, o_send_start, o_done);
        end
        tick();
        i_send_done = 1'b1;
        tick();
        i_send_done = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL start_wait_cmd: got en/ss/dn=%b%b%b want 000",
                     o_enable, o_send_start, o_done);
        end
    endtask

    task automatic test_steps();
        for (int k = 1; k <= 20; k++) begin
            i_rx_done = 1'b1;
            i_rx_data = 8'd4;
            tick();
            i_rx_done = 1'b0;
            n_checks++;
            if ({o_enable, o_send_start, o_done, o_clk_count} !==
                {3'b100, 32'(k - 1)}) begin
                n_fail++;
                $display("FAIL step_enable[%0d]: got en/ss/dn=%b%b%b cnt=%0d want 100 cnt=%0d",
                         k, o_enable, o_send_start, o_done, o_clk_count, k - 1);
            end
            tick();
            n_checks++;
            if ({o_enable, o_send_start, o_done, o_clk_count} !==
                {3'b010, 32'(k)}) begin
                n_fail++;
                $display("FAIL step_send[%0d]: got en/ss/dn=%b%b%b cnt=%0d want 010 cnt=%0d",
                         k, o_enable, o_send_start, o_done, o_clk_count, k);
            end
            for (int j = 0; j < 3; j++) begin
                tick();
                n_checks++;
                if ({o_enable, o_send_start, o_done} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL step_quiet[%0d.%0d]: got en/ss/dn=%b%b%b want 000",
                             k, j, o_enable, o_send_start, o_done);
                end
            end
            i_send_done = 1'b1;
            tick();
            i_send_done = 1'b0;
        end
    endtask

    task automatic test_stop();
        i_rx_done = 1'b1;
        i_rx_data = 8'd5;
        tick();
        i_rx_done = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b001, 32'd20}) begin
            n_fail++;
            $display("FAIL stop_done: got en/ss/dn=%b%b%b cnt=%0d want 001 cnt=20",
                     o_enable, o_send_start, o_done, o_clk_count);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b000, 32'd20}) begin
                n_fail++;
                $display("FAIL stop_hold[%0d]: got en/ss/dn=%b%b%b cnt=%0d want 000 cnt=20",
                         i, o_enable, o_send_start, o_done, o_clk_count);
            end
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b010, 32'd0}) begin
            n_fail++;
            $display("FAIL restart_clear: got en/ss/dn=%b%b%b cnt=%0d want 010 cnt=0",
                     o_enable, o_send_start, o_done, o_clk_count);
        end
        tick();
    endtask

    task automatic test_ignored();
        i_rx_done = 1'b1;
        i_rx_data = 8'd4;
        tick();
        i_rx_done = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rx_in_wait_send: got en/ss/dn=%b%b%b want 000",
                     o_enable, o_send_start, o_done);
        end
        tick();
        n_checks++;
        if ({o_enable, o_send_start, o_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rx_in_wait_send_late: got en/ss/dn=%b%b%b want 000",
                     o_enable, o_send_start, o_done);
        end
        i_send_done = 1'b1;
        tick();
        i_send_done = 1'b0;
        i_rx_done = 1'b1;
        i_rx_data = 8'd7;
        tick();
        i_rx_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b000, 32'd0}) begin
                n_fail++;
                $display("FAIL bad_opcode[%0d]: got en/ss/dn=%b%b%b cnt=%0d want 000 cnt=0",
                         i, o_enable, o_send_start, o_done, o_clk_count);
            end
            tick();
        end
        i_send_done = 1'b1;
        tick();
        i_send_done = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL extra_send_done: got en/ss/dn=%b%b%b want 000",
                     o_enable, o_send_start, o_done);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b000, 32'd0}) begin
            n_fail++;
            $display("FAIL start_mid_session: got en/ss/dn=%b%b%b cnt=%0d want 000 cnt=0",
                     o_enable, o_send_start, o_done, o_clk_count);
        end
        i_rx_done = 1'b1;
        i_rx_data = 8'd4;
        tick();
        i_rx_done = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL step_after_ignored: got en/ss/dn=%b%b%b cnt=%0d want 100 cnt=0",
                     o_enable, o_send_start, o_done, o_clk_count);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b000, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_in_step: got en/ss/dn=%b%b%b cnt=%0d want 000 cnt=0",
                     o_enable, o_send_start, o_done, o_clk_count);
        end
        tick();
        n_checks++;
        if ({o_enable, o_send_start, o_done, o_clk_count} !== {3'b000, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_in_step_idle: got en/ss/dn=%b%b%b cnt=%0d want 000 cnt=0",
                     o_enable, o_send_start, o_done, o_clk_count);
        end
        i_start = 1'b1;
        rst = 1'b1;
        tick();
        i_start = 1'b0;
        rst = 1'b0;
        n_checks++;
        if ({o_enable, o_send_start, o_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_priority: got en/ss/dn=%b%b%b want 000",
                     o_enable, o_send_start, o_done);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        i_start     = 1'b0;
        i_rx_done   = 1'b0;
        i_rx_data   = 8'd0;
        i_send_done = 1'b0;
        test_reset();
        test_start();
        test_steps();
        test_stop();
        test_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
